cond_unit: RTL

Conditional-execution stage directly downstream of the ALU in the ARMv4 datapath. It holds the architectural NZCV flag register, updates it from the ALU's `aluflags` when an instruction is allowed to set flags, and evaluates the 4-bit condition field of each instruction against the stored flags. It gates register write, memory write and PC-source enables. After a taken branch it squashes a programmable number of following instruction slots.

---
 rtl/cond_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage after the ALU. Holds NZCV,
// evaluates the condition field, gates the write enables and squashes
// a fixed number of slots after a taken branch.
//
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   valid, stall      - slot occupancy and stage hold
//   cond              - instruction condition field (instr[31:28])
//   aluflags, flagw   - ALU {N,Z,C,V} and per-pair flag write request
//   regw, memw, pcs   - decoder enables before gating
//   nowrite           - compare-type instruction, no register write
//   flags             - stored {N,Z,C,V}
//   condex            - condition passed and slot is live
//   regwrite,memwrite - gated write enables
//   pcsrc             - gated PC-source select (taken branch)
//   flush             - current slot is being squashed
module cond_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic       stall,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic [1:0] flagw,
    input  logic       regw,
    input  logic       memw,
    input  logic       pcs,
    input  logic       nowrite,
    output logic [3:0] flags,
    output logic       condex,
    output logic       regwrite,
    output logic       memwrite,
    output logic       pcsrc,
    output logic       flush
);

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    logic [2:0] fcnt;
    logic       condpass;
    logic       live;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags;

    // Evaluated on the stored flags only; there is no aluflags bypass.
    always_comb begin
        condpass = 1'b0;
        unique case (cond)
            4'b0000: condpass = z_f;
            4'b0001: condpass = !z_f;
            4'b0010: condpass = c_f;
            4'b0011: condpass = !c_f;
            4'b0100: condpass = n_f;
            4'b0101: condpass = !n_f;
            4'b0110: condpass = v_f;
            4'b0111: condpass = !v_f;
            4'b1000: condpass = c_f && !z_f;
            4'b1001: condpass = !c_f || z_f;
            4'b1010: condpass = (n_f == v_f);
            4'b1011: condpass = (n_f != v_f);
            4'b1100: condpass = !z_f && (n_f == v_f);
            4'b1101: condpass = z_f || (n_f != v_f);
            4'b1110: condpass = 1'b1;
            4'b1111: condpass = 1'b0;
        endcase
    end

    assign flush    = (fcnt != 3'd0);
    assign live     = valid && !stall && !flush;
    assign condex   = live && condpass;
    assign regwrite = condex && regw && !nowrite;
    assign memwrite = condex && memw;
    assign pcsrc    = condex && pcs;

    always_ff @(posedge clock) begin
        if (reset) begin
            flags <= 4'b0000;
            fcnt  <= 3'd0;
        end else begin
            // condex is already low on stalled or squashed slots.
            if (condex) begin
                if (flagw[1]) flags[3:2] <= aluflags[3:2];
                if (flagw[0]) flags[1:0] <= aluflags[1:0];
            end
            // A squashed slot counts down even with valid low.
            if (pcsrc)
                fcnt <= FLUSH_LD;
            else if (flush && !stall)
                fcnt <= fcnt - 3'd1;
        end
    end

endmodule
